// File: rtl/kim_mux_arb_nto1_pkg.sv
// Shared constants and helpers for the N-to-1 arbitrated output mux.
package kim_mux_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Ceiling log2 for small positive values (channel counts up to 16)
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Select-index width, never narrower than one bit
  function automatic int selWidth(input int numIn);
    return (clog2(numIn) < 1) ? 1 : clog2(numIn);
  endfunction

endpackage

// File: rtl/kim_mux_arb_nto1_if.sv
// Producer-side valid/ready channels plus the single registered consumer port.
interface kim_mux_arb_nto1_if
  import kim_mux_pkg::*;
#(
  parameter int MUX_DATA_WIDTH = 32,
  parameter int MUX_NUM_IN     = 4,
  parameter int SEL_WIDTH      = selWidth(MUX_NUM_IN)
);

  logic [MUX_NUM_IN-1:0]                in_valid;
  logic [MUX_NUM_IN*MUX_DATA_WIDTH-1:0] in_data;
  logic [MUX_NUM_IN-1:0]                in_ready;
  logic                                 out_valid;
  logic [MUX_DATA_WIDTH-1:0]            out_data;
  logic [SEL_WIDTH-1:0]                 out_sel;
  logic                                 out_ready;

  // Environment side: producers and consumer
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  // Mux side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/kim_mux_arb_nto1_rr_arbiter.sv
// Grant logic for the N-to-1 mux: fixed priority or round-robin with a
// pointer that only moves when the granted request is actually taken.
module kim_rr_arbiter
  import kim_mux_pkg::*;
#(
  parameter int  NUM_REQ  = 4,
  parameter int  ARB_MODE = ARB_FIXED,
  localparam int IDX_W    = selWidth(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [IDX_W-1:0]   grant_idx,
  input  logic               advance
);

  localparam logic [IDX_W:0]   NUM_REQ_EXT = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W:0]   candidate;
  logic             found;

  // Scan upward from the pointer with wrap; in fixed mode the pointer stays 0
  always_comb begin
    found        = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    candidate    = '0;
    if (en && !rst) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        candidate = {1'b0, ptr_q} + (IDX_W+1)'(off);
        if (candidate >= NUM_REQ_EXT) begin
          candidate = candidate - NUM_REQ_EXT;
        end
        if (!found && req[candidate[IDX_W-1:0]]) begin
          found     = 1'b1;
          grant_idx = candidate[IDX_W-1:0];
        end
      end
      if (found) begin
        grant_onehot = NUM_REQ'(1) << grant_idx;
      end
    end
  end

  // Next pointer: one past the channel just served, wrapping to 0
  always_comb begin
    ptr_d = ptr_q;
    if (ARB_MODE == ARB_RR && advance) begin
      ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/kim_mux_arb_nto1.sv
// N-to-1 valid/ready mux with an internal arbiter and a registered,
// pipe-through output stage (a new word may load in the cycle the old one leaves).
module kim_mux_arb_nto1
  import kim_mux_pkg::*;
#(
  parameter int  MUX_DATA_WIDTH = 32,
  parameter int  MUX_NUM_IN     = 4,
  parameter int  ARB_MODE       = ARB_FIXED,
  localparam int SEL_WIDTH      = selWidth(MUX_NUM_IN)
) (
  input logic              clk,
  input logic              rst,
  kim_mux_arb_nto1_if.slave bus
);

  logic                      loadEn;
  logic                      transfer;
  logic [MUX_NUM_IN-1:0]     grantOnehot;
  logic [SEL_WIDTH-1:0]      grantIdx;
  logic [MUX_DATA_WIDTH-1:0] selData;

  logic                      outValid_q;
  logic                      outValid_d;
  logic [MUX_DATA_WIDTH-1:0] outData_q;
  logic [MUX_DATA_WIDTH-1:0] outData_d;
  logic [SEL_WIDTH-1:0]      outSel_q;
  logic [SEL_WIDTH-1:0]      outSel_d;

  // The output register can take a word when empty or when its word is leaving
  assign loadEn = !outValid_q || bus.out_ready;

  kim_rr_arbiter #(
    .NUM_REQ  (MUX_NUM_IN),
    .ARB_MODE (ARB_MODE)
  ) u_arbiter (
    .clk          (clk),
    .rst          (rst),
    .req          (bus.in_valid),
    .en           (loadEn),
    .grant_onehot (grantOnehot),
    .grant_idx    (grantIdx),
    .advance      (transfer)
  );

  assign bus.in_ready  = grantOnehot;
  assign transfer      = |(bus.in_valid & grantOnehot);
  assign bus.out_valid = outValid_q;
  assign bus.out_data  = outData_q;
  assign bus.out_sel   = outSel_q;

  // Pick the granted channel's data word (grant is one-hot or zero)
  always_comb begin
    selData = '0;
    for (int i = 0; i < MUX_NUM_IN; i++) begin
      if (grantOnehot[i]) begin
        selData = bus.in_data[i*MUX_DATA_WIDTH +: MUX_DATA_WIDTH];
      end
    end
  end

  // Output stage next state: load on transfer, drain to empty when idle, hold on stall
  always_comb begin
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outSel_d   = outSel_q;
    if (loadEn) begin
      outValid_d = transfer;
      if (transfer) begin
        outData_d = selData;
        outSel_d  = grantIdx;
      end
    end
  end

  // Output register; reset discards any held word
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outSel_q   <= '0;
    end else begin
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outSel_q   <= outSel_d;
    end
  end

endmodule
